// File: rtl/ddc_cic_decim_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// ddc_cic_decim_if : I/Q sample bus into and out of the CIC decimator
// rev 1.0
// ---------------------------------------------------------------------
interface ddc_cic_decim_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16
);
   logic                    din_valid;
   logic signed [IN_W-1:0]  din_i;
   logic signed [IN_W-1:0]  din_q;
   logic                    dout_valid;
   logic signed [OUT_W-1:0] dout_i;
   logic signed [OUT_W-1:0] dout_q;

   modport master (
      output din_valid, din_i, din_q,
      input  dout_valid, dout_i, dout_q
   );

   modport slave (
      input  din_valid, din_i, din_q,
      output dout_valid, dout_i, dout_q
   );
endinterface
`default_nettype wire

// File: rtl/ddc_cic_decim.sv
`default_nettype none
// ---------------------------------------------------------------------
// ddc_cic_decim : 2-channel 3-stage CIC decimator, R = 2/4/8/16, rounded
// and saturated unity-gain output with warm-up suppression.  rev 1.0
// ---------------------------------------------------------------------
module ddc_cic_decim #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 16,
   parameter int ACC_W  = 28,
   parameter int WARMUP = 3
) (
   input  wire logic        clk_200m,
   input  wire logic        cfg_rst,
   ddc_cic_decim_if.slave   bus,
   input  wire logic [1:0]  dec_sel,
   input  wire logic        cfg_load,
   output logic             sat_flag,
   output logic [63:0]      dbg
);
   localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

   logic [1:0]              r_sel;
   logic [3:0]              dec_cnt;
   logic [1:0]              warm_cnt;
   logic                    dec_stb, stb1, stb2, stb3;
   logic                    valid_r;
   logic                    frame_end;
   logic [3:0]              shift;

   logic signed [ACC_W-1:0] din_x [2];
   logic signed [ACC_W-1:0] int1  [2];
   logic signed [ACC_W-1:0] int2  [2];
   logic signed [ACC_W-1:0] int3  [2];
   logic signed [ACC_W-1:0] c1    [2];
   logic signed [ACC_W-1:0] c2    [2];
   logic signed [ACC_W-1:0] c3    [2];
   logic signed [ACC_W-1:0] d1    [2];
   logic signed [ACC_W-1:0] d2    [2];
   logic signed [ACC_W-1:0] d3    [2];
   logic signed [ACC_W:0]   rnd   [2];
   logic signed [OUT_W-1:0] sat_val [2];
   logic signed [OUT_W-1:0] out_reg [2];
   logic [1:0]              clip;

   always_comb begin
      shift     = 4'd3 * ({2'b00, r_sel} + 4'd1);
      frame_end = ({1'b0, dec_cnt} == ((5'd2 << r_sel) - 5'd1));
      din_x[0]  = {{(ACC_W-IN_W){bus.din_i[IN_W-1]}}, bus.din_i};
      din_x[1]  = {{(ACC_W-IN_W){bus.din_q[IN_W-1]}}, bus.din_q};
      clip      = 2'b00;
      for (int c = 0; c < 2; c++) begin
         // one guard bit keeps the half-LSB addition from wrapping
         rnd[c] = $signed({c3[c][ACC_W-1], c3[c]})
                + $signed((ACC_W+1)'(1) << (shift - 4'd1));
         rnd[c] = rnd[c] >>> shift;
         sat_val[c] = rnd[c][OUT_W-1:0];
         if (rnd[c] > OUT_MAX) begin
            sat_val[c] = OUT_MAX[OUT_W-1:0];
            clip[c]    = 1'b1;
         end else if (rnd[c] < OUT_MIN) begin
            sat_val[c] = OUT_MIN[OUT_W-1:0];
            clip[c]    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_200m or posedge cfg_rst) begin
      if (cfg_rst) begin
         r_sel    <= 2'd0;
         dec_cnt  <= 4'd0;
         warm_cnt <= 2'd0;
         dec_stb  <= 1'b0;
         stb1     <= 1'b0;
         stb2     <= 1'b0;
         stb3     <= 1'b0;
         valid_r  <= 1'b0;
         sat_flag <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            int1[c] <= '0; int2[c] <= '0; int3[c] <= '0;
            c1[c]   <= '0; c2[c]   <= '0; c3[c]   <= '0;
            d1[c]   <= '0; d2[c]   <= '0; d3[c]   <= '0;
            out_reg[c] <= '0;
         end
      end else if (cfg_load) begin
         // restart: pipeline strobes die here so no stale sample escapes
         r_sel    <= dec_sel;
         dec_cnt  <= 4'd0;
         warm_cnt <= 2'd0;
         dec_stb  <= 1'b0;
         stb1     <= 1'b0;
         stb2     <= 1'b0;
         stb3     <= 1'b0;
         valid_r  <= 1'b0;
         sat_flag <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            int1[c] <= '0; int2[c] <= '0; int3[c] <= '0;
            c1[c]   <= '0; c2[c]   <= '0; c3[c]   <= '0;
            d1[c]   <= '0; d2[c]   <= '0; d3[c]   <= '0;
         end
      end else begin
         if (bus.din_valid) begin
            dec_cnt <= frame_end ? 4'd0 : dec_cnt + 4'd1;
            for (int c = 0; c < 2; c++) begin
               int1[c] <= int1[c] + din_x[c];
               int2[c] <= int2[c] + int1[c];
               int3[c] <= int3[c] + int2[c];
            end
         end
         dec_stb <= bus.din_valid & frame_end;
         stb1    <= dec_stb;
         stb2    <= stb1;
         stb3    <= stb2;
         for (int c = 0; c < 2; c++) begin
            if (dec_stb) begin
               c1[c] <= int3[c] - d1[c];
               d1[c] <= int3[c];
            end
            if (stb1) begin
               c2[c] <= c1[c] - d2[c];
               d2[c] <= c1[c];
            end
            if (stb2) begin
               c3[c] <= c2[c] - d3[c];
               d3[c] <= c2[c];
            end
         end
         valid_r <= 1'b0;
         if (stb3) begin
            if (clip != 2'b00)
               sat_flag <= 1'b1;
            if (warm_cnt == 2'(WARMUP)) begin
               valid_r    <= 1'b1;
               out_reg[0] <= sat_val[0];
               out_reg[1] <= sat_val[1];
            end else begin
               warm_cnt <= warm_cnt + 2'd1;
            end
         end
      end
   end

   assign bus.dout_valid = valid_r;
   assign bus.dout_i     = out_reg[0];
   assign bus.dout_q     = out_reg[1];
   assign dbg = {dec_cnt, warm_cnt, r_sel, 8'h00,
                 {(48-ACC_W){int3[0][ACC_W-1]}}, int3[0]};
endmodule
`default_nettype wire

// File: tb/tb_ddc_cic_decim.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ddc_cic_decim: closed-form CIC reference (binomial comb over
// cubic-weighted input sums) with timed expectation queue.
module tb_ddc_cic_decim;
   localparam int WARMUP = 3;
   typedef struct { int due; logic [15:0] i; logic [15:0] q; } exp_t;

   logic        clk_200m = 1'b0;
   logic        cfg_rst  = 1'b1;
   logic        cfg_load = 1'b0;
   logic [1:0]  dec_sel  = 2'd0;
   logic        sat_flag;
   logic [63:0] dbg;

   ddc_cic_decim_if bus ();

   ddc_cic_decim dut (
      .clk_200m (clk_200m),
      .cfg_rst  (cfg_rst),
      .bus      (bus),
      .dec_sel  (dec_sel),
      .cfg_load (cfg_load),
      .sat_flag (sat_flag),
      .dbg      (dbg)
   );

   always #2.5 clk_200m = ~clk_200m;

   int          hist_i[$];
   int          hist_q[$];
   exp_t        pend[$];
   int          rr = 2, shift = 3, cyc = 0;
   int          checks = 0, errors = 0;
   logic        exp_valid = 1'b0, exp_sat = 1'b0;
   logic [15:0] exp_i = '0, exp_q = '0;
   logic [47:0] exp_int3 = '0;

   // Third integrator after n inputs: sum of x[i] * C(n-1-i, 2).
   function automatic longint f3(input bit ch, input int n);
      longint s = 0;
      for (int i = 0; i < n - 2; i++)
         s += longint'(ch ? hist_q[i] : hist_i[i]) * longint'((n-2-i)*(n-1-i)/2);
      return s;
   endfunction

   function automatic longint cic_out(input bit ch, input int m);
      longint y;
      y = f3(ch, m*rr) - 3*f3(ch, (m-1)*rr) + 3*f3(ch, (m-2)*rr) - f3(ch, (m-3)*rr);
      return (y + (longint'(1) <<< (shift-1))) >>> shift;
   endfunction

   task automatic model_clear(input logic [1:0] sel);
      hist_i.delete(); hist_q.delete(); pend.delete();
      rr = 2 << sel; shift = 3 * (int'(sel) + 1); exp_sat = 1'b0;
   endtask

   task automatic drive(input logic v, input logic [15:0] di, input logic [15:0] dq,
                        input logic ld, input logic [1:0] sel);
      int m; longint yi, yq, f; logic [27:0] lo;
      bus.din_valid = v; bus.din_i = di; bus.din_q = dq;
      cfg_load = ld; dec_sel = sel;
      @(posedge clk_200m);
      cyc++;
      if (ld) model_clear(sel);
      else if (v) begin
         hist_i.push_back(int'($signed(di)));
         hist_q.push_back(int'($signed(dq)));
         if (hist_i.size() % rr == 0) begin
            m  = hist_i.size() / rr;
            yi = cic_out(1'b0, m);
            yq = cic_out(1'b1, m);
            if (yi > 32767 || yi < -32768 || yq > 32767 || yq < -32768) exp_sat = 1'b1;
            yi = (yi > 32767) ? 32767 : (yi < -32768) ? -32768 : yi;
            yq = (yq > 32767) ? 32767 : (yq < -32768) ? -32768 : yq;
            if (m > WARMUP) pend.push_back('{due: cyc + 4, i: 16'(yi), q: 16'(yq)});
         end
      end
      exp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_valid = 1'b1; exp_i = pend[0].i; exp_q = pend[0].q;
         void'(pend.pop_front());
      end
      f = f3(1'b0, hist_i.size()); lo = f[27:0];
      exp_int3 = {{20{lo[27]}}, lo};
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.dout_i !== 16'd0 || bus.dout_q !== 16'd0) begin
         errors++; $display("FAIL reset_out got v=%b i=%h q=%h want 0", bus.dout_valid, bus.dout_i, bus.dout_q);
      end
      checks++;
      if (dbg !== 64'd0) begin errors++; $display("FAIL reset_dbg got %h want 0", dbg); end
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat_flag); end
   endtask

   task automatic test_dc_r16();
      int seen = 0;
      drive(1'b0, 16'd0, 16'd0, 1'b1, 2'd3);
      for (int n = 0; n < 136; n++) begin
         drive(n < 128, 16'd1000, 16'hFC18, 1'b0, 2'd3);
         checks++;
         if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL dc16_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (bus.dout_i !== exp_i || bus.dout_q !== exp_q) begin errors++; $display("FAIL dc16_data cyc=%0d got %h/%h want %h/%h", cyc, bus.dout_i, bus.dout_q, exp_i, exp_q); end
         end
         if (bus.dout_valid) seen++;
      end
      checks++;
      if (seen != 5) begin errors++; $display("FAIL dc16_count got %0d want 5", seen); end
      checks++;
      if (bus.dout_i !== 16'd1000 || bus.dout_q !== 16'hFC18) begin errors++; $display("FAIL dc16_value got %h/%h want 03e8/fc18", bus.dout_i, bus.dout_q); end
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("FAIL dc16_sat got %b want 0", sat_flag); end
   endtask

   task automatic test_full_scale_r2();
      drive(1'b0, 16'd0, 16'd0, 1'b1, 2'd0);
      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 0; n < 48; n++) begin
            if (ph == 0) drive(n < 40, 16'h7FFF, 16'h8000, 1'b0, 2'd0);
            else         drive(n < 40, n[0] ? 16'h8000 : 16'h7FFF, n[0] ? 16'h7FFF : 16'h8000, 1'b0, 2'd0);
            checks++;
            if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL fs2_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
            if (exp_valid) begin
               checks++;
               if (bus.dout_i !== exp_i || bus.dout_q !== exp_q) begin errors++; $display("FAIL fs2_data cyc=%0d got %h/%h want %h/%h", cyc, bus.dout_i, bus.dout_q, exp_i, exp_q); end
            end
         end
         checks++;
         if (ph == 0 && (bus.dout_i !== 16'h7FFF || bus.dout_q !== 16'h8000)) begin errors++; $display("FAIL fs2_dc got %h/%h want 7fff/8000", bus.dout_i, bus.dout_q); end
         if (ph == 1 && (bus.dout_i !== 16'h0000 || bus.dout_q !== 16'h0000)) begin errors++; $display("FAIL fs2_alt got %h/%h want 0000/0000", bus.dout_i, bus.dout_q); end
      end
      checks++;
      if (sat_flag !== 1'b0) begin errors++; $display("FAIL fs2_sat got %b want 0", sat_flag); end
   endtask

   task automatic test_gapped_r4();
      int last_v = -1;
      drive(1'b0, 16'd0, 16'd0, 1'b1, 2'd1);
      for (int n = 0; n < 104; n++) begin
         drive((n % 3 == 0) && (n < 96), 16'd500, 16'hFE0C, 1'b0, 2'd1);
         checks++;
         if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL gap4_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (bus.dout_i !== 16'd500 || bus.dout_q !== 16'hFE0C) begin errors++; $display("FAIL gap4_data cyc=%0d got %h/%h want 01f4/fe0c", cyc, bus.dout_i, bus.dout_q); end
         end
         if (bus.dout_valid) begin
            if (last_v >= 0) begin
               checks++;
               if (cyc - last_v != 12) begin errors++; $display("FAIL gap4_period got %0d want 12", cyc - last_v); end
            end
            last_v = cyc;
         end
      end
   endtask

   task automatic test_reload();
      int seen = 0;
      drive(1'b0, 16'd0, 16'd0, 1'b1, 2'd2);
      for (int n = 0; n < 43; n++) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, 2'd2);
         checks++;
         if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL reload_r8_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (bus.dout_i !== exp_i || bus.dout_q !== exp_q) begin errors++; $display("FAIL reload_r8_data cyc=%0d got %h/%h want %h/%h", cyc, bus.dout_i, bus.dout_q, exp_i, exp_q); end
         end
      end
      drive(1'b1, 16'h7000, 16'h7000, 1'b1, 2'd1);
      checks++;
      if (dbg[57:56] !== 2'd1 || dbg[63:58] !== 6'd0 || sat_flag !== 1'b0) begin errors++; $display("FAIL reload_cfg got dbg=%h sat=%b want rsel=1 cnt=0 sat=0", dbg, sat_flag); end
      for (int n = 0; n < 32; n++) begin
         drive(n < 24, 16'hFD44, 16'd700, 1'b0, 2'd1);
         checks++;
         if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL reload_r4_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (bus.dout_i !== 16'hFD44 || bus.dout_q !== 16'd700) begin errors++; $display("FAIL reload_r4_data cyc=%0d got %h/%h want fd44/02bc", cyc, bus.dout_i, bus.dout_q); end
         end
         if (bus.dout_valid) seen++;
      end
      checks++;
      if (seen != 3) begin errors++; $display("FAIL reload_count got %0d want 3", seen); end
   endtask

   task automatic test_async_reset();
      int seen = 0;
      drive(1'b0, 16'd0, 16'd0, 1'b1, 2'd1);
      for (int n = 0; n < 10; n++) drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, 2'd1);
      bus.din_valid = 1'b0;
      #1 cfg_rst = 1'b1;
      #1;
      checks++;
      if (bus.dout_valid !== 1'b0 || bus.dout_i !== 16'd0 || bus.dout_q !== 16'd0 || dbg !== 64'd0 || sat_flag !== 1'b0) begin
         errors++; $display("FAIL arst_now got v=%b i=%h q=%h dbg=%h sat=%b want all 0", bus.dout_valid, bus.dout_i, bus.dout_q, dbg, sat_flag);
      end
      repeat (2) @(posedge clk_200m);
      #1 cfg_rst = 1'b0;
      model_clear(2'd0);
      for (int n = 0; n < 20; n++) begin
         drive(n < 12, 16'd123, 16'hFF85, 1'b0, 2'd3);
         checks++;
         if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL arst_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (bus.dout_i !== 16'd123 || bus.dout_q !== 16'hFF85) begin errors++; $display("FAIL arst_data cyc=%0d got %h/%h want 007b/ff85", cyc, bus.dout_i, bus.dout_q); end
         end
         if (bus.dout_valid) seen++;
      end
      checks++;
      if (seen != 3 || dbg[57:56] !== 2'd0) begin errors++; $display("FAIL arst_r2 got outputs=%0d rsel=%0d want 3/0", seen, dbg[57:56]); end
   endtask

   task automatic test_sine_r8();
      drive(1'b0, 16'd0, 16'd0, 1'b1, 2'd2);
      for (int n = 0; n < 808; n++) begin
         drive(n < 800, 16'(int'(32000.0 * $sin(6.283185307 * n / 100.0))),
               16'(int'(32000.0 * $cos(6.283185307 * n / 100.0))), 1'b0, 2'd2);
         checks++;
         if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL sine_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
         if (exp_valid) begin
            checks++;
            if (bus.dout_i !== exp_i || bus.dout_q !== exp_q) begin errors++; $display("FAIL sine_data cyc=%0d got %h/%h want %h/%h", cyc, bus.dout_i, bus.dout_q, exp_i, exp_q); end
         end
      end
      checks++;
      if (sat_flag !== exp_sat) begin errors++; $display("FAIL sine_sat got %b want %b", sat_flag, exp_sat); end
   endtask

   task automatic test_random();
      logic [1:0] sel;
      for (int r = 0; r < 4; r++) begin
         sel = 2'($urandom_range(0, 3));
         drive(1'b0, 16'd0, 16'd0, 1'b1, sel);
         for (int n = 0; n < 208; n++) begin
            drive((n < 200) && ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'b0, sel);
            checks++;
            if (bus.dout_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, bus.dout_valid, exp_valid); end
            if (exp_valid) begin
               checks++;
               if (bus.dout_i !== exp_i || bus.dout_q !== exp_q) begin errors++; $display("FAIL rand_data cyc=%0d got %h/%h want %h/%h", cyc, bus.dout_i, bus.dout_q, exp_i, exp_q); end
            end
            checks++;
            if (dbg[47:0] !== exp_int3 || dbg[63:60] !== 4'(hist_i.size() % rr) || dbg[55:48] !== 8'd0 || dbg[57:56] !== sel) begin
               errors++; $display("FAIL rand_dbg cyc=%0d got %h want int3=%h cnt=%0d sel=%0d", cyc, dbg, exp_int3, hist_i.size() % rr, sel);
            end
         end
         checks++;
         if (sat_flag !== exp_sat) begin errors++; $display("FAIL rand_sat got %b want %b", sat_flag, exp_sat); end
      end
   endtask

   initial begin
      bus.din_valid = 1'b0; bus.din_i = '0; bus.din_q = '0;
      repeat (3) @(posedge clk_200m);
      #1;
      test_reset();
      cfg_rst = 1'b0;
      model_clear(2'd0);
      test_dc_r16();
      test_full_scale_r2();
      test_gapped_r4();
      test_reload();
      test_async_reset();
      test_sine_r8();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ddc_cic_decim.md
Name: ddc_cic_decim

Overview:
- Two-channel (I/Q) 3-stage CIC decimator that sits directly downstream of the DDC mixer.
- Consumes the mixer's 16-bit I/Q words at the clk_200m rate and decimates by a programmable power of two (2/4/8/16).
- Emits unity-gain, rounded and saturated 16-bit I/Q samples with a single-cycle valid strobe for the following FIR/compensation stage.

Parameters:
- IN_W, 16, input sample width (two's complement)
- OUT_W, 16, output sample width
- ACC_W, 28, integrator/comb width = IN_W + 3*log2(16); all arithmetic is modulo 2^ACC_W
- WARMUP, 3, output samples suppressed after reset/cfg_load

Ports:
- clk_200m  in  1  system clock
- cfg_rst  in  1  asynchronous active-high reset
- din_valid  in  1  input sample qualifier (tie high for continuous mixer output)
- din_i  in  16  mixer I sample, signed
- din_q  in  16  mixer Q sample, signed
- dec_sel  in  2  decimation select: 0=R2, 1=R4, 2=R8, 3=R16
- cfg_load  in  1  one-cycle pulse; latches dec_sel and restarts the filter
- dout_valid  out  1  one-cycle strobe, output sample valid
- dout_i  out  16  decimated I, signed
- dout_q  out  16  decimated Q, signed
- sat_flag  out  1  sticky; set on any output saturation, cleared by reset/cfg_load
- dbg  out  64  {dec_cnt[3:0], warm_cnt[1:0], r_sel[1:0], 8'b0, int3_i[27:0] sign-extended to 48}

Behaviour:
- Reset (async on cfg_rst): all integrators, combs, dec_cnt, warm_cnt and outputs go to 0; dout_valid=0, sat_flag=0; r_sel=0 (R2).
- dec_sel is used only through r_sel. r_sel loads on the edge where cfg_load=1.
- cfg_load also acts as a synchronous clear in that cycle: clears all filter state, dec_cnt, warm_cnt and sat_flag. Any din_valid in the same cycle is discarded.
- Integrators, per channel, update only when din_valid=1:
  - int1 <= int1 + sext(din)
  - int2 <= int2 + int1
  - int3 <= int3 + int2
  - Each stage uses pre-edge register values. Wrap-around is intentional and harmless.
- dec_cnt counts valid inputs 0..R-1 and wraps to 0. On a din_valid with dec_cnt==R-1, dec_stb is registered high for one cycle.
- Comb section runs on dec_stb. It is a 3-stage pipeline, one register per stage, each y = x - x_delayed(one decimated sample). The delay registers update only on their stage strobe.
- Scaling:
  - shift = 3*(r_sel+1), i.e. 3/6/9/12.
  - Rounding is round-half-up: add 2^(shift-1), then arithmetic right shift.
  - Saturate to [-32768, 32767]. Any clipping sets sat_flag.
- Latency: dout_valid rises exactly 5 clk_200m cycles after the din_valid cycle that completes a decimation frame (edge k+1 dec_stb, k+2..k+4 combs, k+5 output register).
- dout_i/dout_q hold their value between strobes.
- Warm-up: the first WARMUP decimated results after reset/cfg_load are computed but dout_valid stays 0 for them. warm_cnt saturates at WARMUP.
- Simultaneous cfg_load and pending pipeline strobes: the clear wins. No dout_valid is produced from pre-load data.
- din_valid gaps stall the integrators and dec_cnt. Comb/output stages still drain on their own strobes.

Test Plan:
- R16, din_valid=1, din_i=1000, din_q=-1000 constant -> after 3 suppressed outputs, dout_valid pulses every 16 cycles with dout_i=1000, dout_q=-1000, sat_flag=0.
- R2, din_i=32767, din_q=-32768 constant -> settled dout_i=32767, dout_q=-32768, sat_flag=0. Then R2 with alternating +/-32768 -> dout_i=0 (or -1 with rounding) and no wrap error.
- R4, din_valid high one cycle in three, DC 500 -> dout_valid every 12 cycles, value 500. Check the pulse lands exactly 5 cycles after every 4th valid input.
- Run R8, then assert cfg_load with dec_sel=1 mid-frame -> no dout_valid for 3 R4 frames plus latency, then period 4, correct DC value, sat_flag cleared.
- Assert cfg_rst asynchronously mid-frame (between clock edges) -> outputs and dbg zero immediately. After release, r_sel=R2 and the first valid output appears after 3 warm-up frames.
- 100-cycle 1 kHz-equivalent sine, R8 -> output matches a bit-exact reference model for every sample, including rounding ties (e.g. int value 4 with shift 3 -> 1).
